// File: rtl/mvm_pkg.sv
// Shared widths and types for the 3x3 matrix-vector multiplier datapath.
package mvm_pkg;

  localparam int ACC_WIDTH  = 28;
  localparam int DATA_WIDTH = 14;
  localparam int MVM_ROWS   = 3;
  localparam int REQ_SHIFT  = 7;

  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: the head entry is readable as soon as it is
// written. Synchronous active-high reset clears pointers and occupancy only.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en, pop_en;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_en   = push_i && !full_o;
  assign pop_en    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/mvm_requant_out.sv
// Requantizing output stage for the MVM: round-shift, saturate, tag the last
// row and buffer in a FWFT FIFO. Define RELU_REQUANT_EN to clamp negatives to 0.
module mvm_requant_out
  import mvm_pkg::*;
#(
  parameter int IN_WIDTH  = ACC_WIDTH,
  parameter int OUT_WIDTH = DATA_WIDTH,
  parameter int SHIFT     = REQ_SHIFT,
  parameter int DEPTH     = 4,
  parameter int ROWS      = MVM_ROWS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic [7:0]                  sat_count
);

  localparam int    ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam longint MAX_L = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam logic signed [IN_WIDTH:0] RND   = (IN_WIDTH+1)'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [IN_WIDTH:0] MAX_Q = (IN_WIDTH+1)'(MAX_L);
  localparam logic signed [IN_WIDTH:0] MIN_Q = (IN_WIDTH+1)'(-MAX_L - 1);

  logic signed [IN_WIDTH:0]    ext_s, sum_s, q_s;
  logic signed [OUT_WIDTH-1:0] q_sat;
  logic                        clip;
  logic                        accept, full, empty, last_row;
  logic [OUT_WIDTH:0]          fifo_rd;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [7:0]                  sat_q, sat_d;

  // The extra top bit keeps the rounding add from wrapping at the largest input.
  always_comb begin
    ext_s = {in_data[IN_WIDTH-1], in_data};
`ifdef RELU_REQUANT_EN
    if (in_data[IN_WIDTH-1]) ext_s = '0;
`endif
    sum_s = ext_s + RND;
    q_s   = sum_s >>> SHIFT;
    clip  = 1'b0;
    q_sat = q_s[OUT_WIDTH-1:0];
    if (q_s > MAX_Q) begin
      q_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      clip  = 1'b1;
    end else if (q_s < MIN_Q) begin
      q_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      clip  = 1'b1;
    end
  end

  // Ready ignores out_ready: a full FIFO refuses even when it pops this cycle.
  assign in_ready = !full && !reset;
  assign accept   = in_valid && in_ready;
  assign last_row = (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    row_d = row_q;
    sat_d = sat_q;
    if (accept) begin
      row_d = last_row ? '0 : row_q + 1'b1;
      if (clip && (sat_q != 8'hFF)) sat_d = sat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      sat_q <= '0;
    end else begin
      row_q <= row_d;
      sat_q <= sat_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (accept),
    .wr_data_i ({last_row, q_sat}),
    .pop_i     (out_ready),
    .rd_data_o (fifo_rd),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : fifo_rd[OUT_WIDTH-1:0];
  assign out_last  = !empty && fifo_rd[OUT_WIDTH];
  assign sat_count = sat_q;

endmodule

// File: tb/tb_mvm_requant_out.sv
// Self-checking bench for mvm_requant_out: directed literal cases plus a
// randomized run against an arithmetic reference model with a scoreboard queue.
module tb_mvm_requant_out;

  localparam int IN_W   = 28;
  localparam int OUT_W  = 14;
  localparam int SH     = 7;
  localparam int DEPTH  = 4;
  localparam int ROWS   = 3;
  localparam longint OMAX = 8191;
  localparam longint OMIN = -8192;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;
  logic [7:0]              sat_count;

  mvm_requant_out dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint w;
    bit     last;
  } entry_t;

  entry_t exp_q[$];
  int     row_m;
  int     sat_m;
  bit     checking = 1'b0;
  int     dut_last_pops;
  int     n_checks = 0;
  int     n_fails  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor((x + 2^(SH-1)) / 2^SH), then clip to the output range.
  function automatic void requant(input longint v, output longint w, output bit clipped);
    longint x;
    longint q;
    x = v;
`ifdef RELU_REQUANT_EN
    if (x < 0) x = 0;
`endif
    q = (x + (longint'(1) <<< (SH - 1))) >>> SH;
    clipped = 1'b0;
    w = q;
    if (q > OMAX) begin
      w = OMAX;
      clipped = 1'b1;
    end else if (q < OMIN) begin
      w = OMIN;
      clipped = 1'b1;
    end
  endfunction

  // Compare, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    longint w;
    bit     c;
    bit     acc;
    bit     pop;
    entry_t e;
    if (checking) begin
      check("in_ready", in_ready, (!reset && exp_q.size() < DEPTH));
      check("out_valid", out_valid, exp_q.size() > 0);
      check("sat_count", sat_count, sat_m);
      if (exp_q.size() > 0) begin
        check("out_data", out_data, exp_q[0].w);
        check("out_last", out_last, exp_q[0].last);
      end
    end
    if (reset) begin
      exp_q.delete();
      row_m    = 0;
      sat_m    = 0;
      checking = 1'b1;
    end else if (checking) begin
      acc = in_valid && (exp_q.size() < DEPTH);
      pop = out_ready && (exp_q.size() > 0);
      if (pop) begin
        if (out_valid && out_last) dut_last_pops++;
        void'(exp_q.pop_front());
      end
      if (acc) begin
        requant(longint'(in_data), w, c);
        e.w    = w;
        e.last = (row_m == ROWS - 1);
        exp_q.push_back(e);
        row_m = (row_m + 1) % ROWS;
        if (c && sat_m < 255) sat_m++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic send_and_pop(input string name, input longint v, input longint exp_w,
                              input longint exp_sat);
    in_valid  = 1'b1;
    in_data   = IN_W'(v);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, exp_w);
    check({name, "_sat"}, sat_count, exp_sat);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic longint rand_in();
    case ($urandom_range(0, 5))
      0:       return longint'($signed(IN_W'($urandom)));
      1:       return longint'($urandom_range(0, 4000)) - 2000;
      2:       return (longint'(1) <<< (IN_W - 1)) - 1;
      3:       return -(longint'(1) <<< (IN_W - 1));
      4:       return 8191 * 128 + longint'($urandom_range(0, 400)) - 200;
      default: return -8192 * 128 + longint'($urandom_range(0, 400)) - 200;
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    do_reset(2);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sat", sat_count, 0);
    #1;

`ifdef RELU_REQUANT_EN
    send_and_pop("relu_neg", -1000, 0, 0);
    send_and_pop("relu_min", -134217728, 0, 0);
    send_and_pop("relu_pos", 1000, 8, 0);
    send_and_pop("relu_max", 134217727, 8191, 1);
`else
    send_and_pop("pos_1000", 1000, 8, 0);
    send_and_pop("neg_1000", -1000, -8, 0);
    send_and_pop("half_up", 64, 1, 0);
    send_and_pop("half_dn", 63, 0, 0);
    send_and_pop("sat_max", 134217727, 8191, 1);
    send_and_pop("sat_min", -134217728, -8192, 2);
    send_and_pop("sat_edge", 1048575, 8191, 3);
`endif

    // Backpressure: 5 offers into a 4-deep FIFO with the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'((i + 1) * 1280);
      step();
      if (i == 3) check("full_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    #1;
    check("full_head", out_data, 10);
    check("full_still", in_ready, 0);
    out_ready = 1'b1;
    step();
    #1;
    check("refill_ready", in_ready, 1);
    check("second_head", out_data, 20);
    repeat (4) step();
    out_ready = 1'b0;

    // Row tagging: 7 words, then 2 more; last rides on words 3, 6 and 9.
    do_reset(1);
    dut_last_pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'(i * 256);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("last_count7", dut_last_pops, 2);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'(i * 512);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("last_count9", dut_last_pops, 3);

    // Reset mid-stream discards buffered words and the partial vector.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = IN_W'(134217727);
    step();
    in_data   = IN_W'(5000);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 0);
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sat", sat_count, 0);
    dut_last_pops = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = IN_W'(i * 640);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("mid_rst_last", dut_last_pops, 1);
    out_ready = 1'b0;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = IN_W'(rand_in());
      step();
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
